// File: rtl/abc_sequencer.sv
// Drives the a/b/c control protocol: a one-cycle a strobe, B_LEN cycles of b,
// then C_COUNT c pulses (throttled by c_en, separated by at least C_GAP idle cycles).
module abc_sequencer #(
    parameter int B_LEN   = 2,
    parameter int C_COUNT = 2,
    parameter int C_GAP   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         c_en,
    output logic                         a,
    output logic                         b,
    output logic                         c,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic [$clog2(C_COUNT+1)-1:0] c_cnt
);

    localparam int CW = $clog2(C_COUNT + 1);
    localparam int BW = (B_LEN > 1) ? $clog2(B_LEN) : 1;
    localparam int GW = $clog2(C_GAP + 1);

    localparam logic [BW-1:0] B_LAST  = BW'(B_LEN - 1);
    localparam logic [CW-1:0] C_FULL  = CW'(C_COUNT);
    localparam logic [GW-1:0] GAP_MIN = GW'(C_GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A,
        S_B,
        S_C,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [BW-1:0]   b_cnt;
    logic [GW-1:0]   gap;
    logic            slot_open;
    logic            c_fire;
    logic            aborted_next;

    always_comb begin
        state_next   = state;
        aborted_next = 1'b0;
        c_fire       = 1'b0;
        slot_open    = (c_cnt == '0) || (gap >= GAP_MIN);

        case (state)
            S_IDLE: begin
                if (start && !abort) state_next = S_A;
            end
            S_A: begin
                state_next = S_B;
            end
            S_B: begin
                // The first c may be launched from the last b cycle so it lands
                // in the first C-state cycle.
                if (b_cnt == B_LAST) begin
                    state_next = S_C;
                    c_fire     = c_en && slot_open;
                end
            end
            S_C: begin
                if (c_cnt == C_FULL) state_next = S_DONE;
                else                 c_fire     = c_en && slot_open;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (abort && (state != S_IDLE)) begin
            state_next   = S_IDLE;
            aborted_next = 1'b1;
            c_fire       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a       <= 1'b0;
            b       <= 1'b0;
            c       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            c_cnt   <= '0;
            b_cnt   <= '0;
            gap     <= '0;
        end else begin
            state   <= state_next;
            a       <= (state_next == S_A);
            b       <= (state_next == S_B);
            c       <= c_fire;
            busy    <= (state_next != S_IDLE);
            done    <= (state_next == S_DONE);
            aborted <= aborted_next;

            b_cnt <= (state == S_B) ? b_cnt + BW'(1) : '0;

            if (state_next == S_A)  c_cnt <= '0;
            else if (c_fire)        c_cnt <= c_cnt + CW'(1);

            // Gap saturates at C_GAP: only "enough idle cycles yet" matters.
            if ((state_next == S_A) || c_fire)            gap <= '0;
            else if ((state == S_C) && (gap != GAP_MIN))  gap <= gap + GW'(1);
        end
    end

endmodule

// File: tb/tb_abc_sequencer.sv
// Bench for abc_sequencer: directed vector table, multi-cycle corner sequences and
// random stimulus against a cycle-arithmetic reference model, on two parameter sets.
module tb_abc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, c_en;
    logic       a1, b1, c1, busy1, done1, ab1;
    logic [1:0] cnt1;
    logic       a2, b2, c2, busy2, done2, ab2;
    logic [1:0] cnt2;

    abc_sequencer #(.B_LEN(2), .C_COUNT(2), .C_GAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .c_en(c_en),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .aborted(ab1), .c_cnt(cnt1)
    );

    abc_sequencer #(.B_LEN(2), .C_COUNT(3), .C_GAP(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .c_en(c_en),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .aborted(ab2), .c_cnt(cnt2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Output vector layout: {a, b, c, busy, done, aborted, c_cnt[1:0]}
    typedef struct {
        bit         run;
        int         age;
        int         pulses;
        int         last;
        logic [7:0] out;
    } model_t;

    typedef struct {
        logic       r;
        logic       s;
        logic       ab;
        logic       ce;
        logic [7:0] exp;
    } vec_t;

    model_t m1, m2;
    vec_t   tbl[$];

    logic prev_a, prev_c;
    int   b_run;

    function automatic logic [7:0] pack1();
        return {a1, b1, c1, busy1, done1, ab1, cnt1};
    endfunction

    function automatic logic [7:0] pack2();
        return {a2, b2, c2, busy2, done2, ab2, cnt2};
    endfunction

    // Next-cycle expectation from the protocol rules, using cycle ages within a run:
    // age 0 is the a cycle, ages 1..blen carry b, later ages are the c phase.
    function automatic model_t mstep(model_t m, int blen, int cnum, int cgap,
                                     logic r, logic s, logic ab, logic ce);
        model_t     n   = m;
        logic [1:0] cnt = m.out[1:0];
        bit         fire;
        n.out = {6'b0, cnt};
        if (r) begin
            n.run = 0;
            n.out = '0;
        end else if (m.run && ab) begin
            n.run    = 0;
            n.out[2] = 1'b1;
        end else if (!m.run) begin
            if (s && !ab) begin
                n.run    = 1;
                n.age    = 0;
                n.pulses = 0;
                n.last   = -1000;
                n.out    = 8'b100_100_00;
            end
        end else if (m.out[3]) begin
            n.run = 0;
        end else if (m.pulses == cnum) begin
            n.out = {3'b000, 1'b1, 1'b1, 1'b0, cnt};
        end else begin
            fire     = ce && (m.age >= blen) && (m.age - m.last >= cgap);
            n.age    = m.age + 1;
            n.out[6] = (n.age <= blen);
            n.out[4] = 1'b1;
            if (fire) begin
                n.pulses   = m.pulses + 1;
                n.last     = n.age;
                n.out[5]   = 1'b1;
                n.out[1:0] = 2'(n.pulses);
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic ab, input logic ce);
        rst   = r;
        start = s;
        abort = ab;
        c_en  = ce;
        m1 = mstep(m1, 2, 2, 1, r, s, ab, ce);
        m2 = mstep(m2, 2, 3, 3, r, s, ab, ce);
        @(negedge clk);
        cyc++;
        check("model_dut1", pack1(), m1.out);
        check("model_dut2", pack2(), m2.out);
        // Protocol monitor on the default-parameter instance
        if (prev_c) check("c_not_consecutive", {7'b0, c1}, 8'd0);
        if (prev_a && !ab1 && !r) check("a_then_b", {7'b0, b1}, 8'd1);
        if (b1) begin
            b_run++;
        end else if (b_run > 0) begin
            if (!ab1 && !r) check("b_len", 8'(b_run), 8'd2);
            b_run = 0;
        end
        prev_a = a1;
        prev_c = c1;
    endtask

    function automatic vec_t mk(logic r, logic s, logic ab, logic ce, logic [7:0] e);
        vec_t v;
        v.r = r; v.s = s; v.ab = ab; v.ce = ce; v.exp = e;
        return v;
    endfunction

    initial begin
        int done_cyc;
        bit have_done;
        int c_cyc[$];
        int c_val[$];
        int done_cnt;

        m1 = '{run: 0, age: 0, pulses: 0, last: 0, out: 8'h00};
        m2 = m1;
        prev_a = 1'b0;
        prev_c = 1'b0;
        b_run  = 0;

        // Defaults, c_en always high, start at relative cycle 2
        tbl.push_back(mk(0,0,0,1, 8'b000_000_00));
        tbl.push_back(mk(0,0,0,1, 8'b000_000_00));
        tbl.push_back(mk(0,1,0,1, 8'b000_000_00));
        tbl.push_back(mk(0,0,0,1, 8'b100_100_00));
        tbl.push_back(mk(0,0,0,1, 8'b010_100_00));
        tbl.push_back(mk(0,0,0,1, 8'b010_100_00));
        tbl.push_back(mk(0,0,0,1, 8'b001_100_01));
        tbl.push_back(mk(0,0,0,1, 8'b000_100_01));
        tbl.push_back(mk(0,0,0,1, 8'b001_100_10));
        tbl.push_back(mk(0,0,0,1, 8'b000_110_10));
        tbl.push_back(mk(0,0,0,0, 8'b000_000_10));
        // c_en held low until relative cycle 10
        tbl.push_back(mk(0,0,0,0, 8'b000_000_10));
        tbl.push_back(mk(0,0,0,0, 8'b000_000_10));
        tbl.push_back(mk(0,1,0,0, 8'b000_000_10));
        tbl.push_back(mk(0,0,0,0, 8'b100_100_00));
        tbl.push_back(mk(0,0,0,0, 8'b010_100_00));
        tbl.push_back(mk(0,0,0,0, 8'b010_100_00));
        for (int i = 6; i < 10; i++) tbl.push_back(mk(0,0,0,0, 8'b000_100_00));
        tbl.push_back(mk(0,0,0,1, 8'b000_100_00));
        tbl.push_back(mk(0,0,0,1, 8'b001_100_01));
        tbl.push_back(mk(0,0,0,1, 8'b000_100_01));
        tbl.push_back(mk(0,0,0,1, 8'b001_100_10));
        tbl.push_back(mk(0,0,0,1, 8'b000_110_10));
        tbl.push_back(mk(0,0,0,1, 8'b000_000_10));
        // Abort in the second b cycle, then a fresh run
        tbl.push_back(mk(0,1,0,1, 8'b000_000_10));
        tbl.push_back(mk(0,0,0,1, 8'b100_100_00));
        tbl.push_back(mk(0,0,0,1, 8'b010_100_00));
        tbl.push_back(mk(0,0,1,1, 8'b010_100_00));
        tbl.push_back(mk(0,1,0,1, 8'b000_001_00));
        tbl.push_back(mk(0,0,0,1, 8'b100_100_00));
        tbl.push_back(mk(0,0,0,1, 8'b010_100_00));
        tbl.push_back(mk(0,0,0,1, 8'b010_100_00));
        tbl.push_back(mk(0,0,0,1, 8'b001_100_01));
        tbl.push_back(mk(0,0,0,1, 8'b000_100_01));
        tbl.push_back(mk(0,0,0,1, 8'b001_100_10));
        tbl.push_back(mk(0,0,0,1, 8'b000_110_10));
        tbl.push_back(mk(0,0,0,1, 8'b000_000_10));
        // Reset in C after one pulse
        tbl.push_back(mk(0,1,0,1, 8'b000_000_10));
        tbl.push_back(mk(0,0,0,1, 8'b100_100_00));
        tbl.push_back(mk(0,0,0,1, 8'b010_100_00));
        tbl.push_back(mk(0,0,0,1, 8'b010_100_00));
        tbl.push_back(mk(1,0,0,1, 8'b001_100_01));
        tbl.push_back(mk(0,0,0,1, 8'b000_000_00));
        tbl.push_back(mk(0,0,0,1, 8'b000_000_00));

        tick(1, 0, 0, 0);
        tick(1, 1, 0, 1);
        check("reset_state", pack1(), 8'h00);
        tick(0, 0, 1, 0);
        check("abort_in_idle", pack1(), 8'h00);

        foreach (tbl[i]) begin
            check($sformatf("vec%0d", i), pack1(), tbl[i].exp);
            tick(tbl[i].r, tbl[i].s, tbl[i].ab, tbl[i].ce);
        end

        // start held high: exactly one IDLE cycle between done and the next a
        have_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick(0, 1, 0, 1);
            if (a1 && have_done) check("restart_gap", 8'(cyc - done_cyc), 8'd2);
            if (done1) begin
                done_cyc  = cyc;
                have_done = 1;
            end
        end

        // Wide-gap instance: pulses 4 cycles apart, c_cnt 1,2,3, one done
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 1);
        tick(0, 1, 0, 1);
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(0, 0, 0, 1);
            if (c2) begin
                c_cyc.push_back(cyc);
                c_val.push_back(int'(cnt2));
            end
            if (done2) done_cnt++;
        end
        check("gap3_pulses", 8'(c_cyc.size()), 8'd3);
        check("gap3_done", 8'(done_cnt), 8'd1);
        for (int i = 0; i < c_cyc.size(); i++) begin
            check("gap3_cnt", 8'(c_val[i]), 8'(i + 1));
            if (i > 0) check("gap3_spacing", 8'(c_cyc[i] - c_cyc[i-1]), 8'd4);
        end

        // Random traffic on both parameter sets
        for (int i = 0; i < 2500; i++) begin
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
